// File: rtl/hazard_sched_ctrl.sv
// Hazard controller for the 5-stage RV64 pipeline: load-use bubbles, taken-branch
// squashing and saturating performance counters. Branch beats hazard in every state.
module hazard_sched_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

  localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_hazard, w_inc_stall, w_inc_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_hazard = idex_memread && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_inc_stall = 1'b0;
    w_inc_flush = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    busy        = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      busy = (r_state != S_RUN);
      if (branch_taken) begin
        // A taken branch from any state squashes both front-end registers.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        w_inc_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_state_nxt = S_FLUSH;
          w_rem_nxt   = FLUSH_RELOAD;
        end else begin
          w_state_nxt = S_RUN;
          w_rem_nxt   = 4'd0;
        end
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_hazard) begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              idex_flush  = 1'b1;
              w_inc_stall = 1'b1;
              if (STALL_CYCLES > 1) begin
                w_state_nxt = S_STALL;
                w_rem_nxt   = STALL_RELOAD;
              end
            end
          end
          S_STALL: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            w_rem_nxt  = r_rem - 4'd1;
            if (r_rem == 4'd1) w_state_nxt = S_RUN;
          end
          S_FLUSH: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_rem_nxt  = r_rem - 4'd1;
            if (r_rem == 4'd1) w_state_nxt = S_RUN;
          end
          default: begin
            w_state_nxt = S_RUN;
            w_rem_nxt   = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_rem       <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_inc_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_inc_flush) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Bench for hazard_sched_ctrl: a default instance and a STALL=3/FLUSH=2/CNT_W=4 instance
// share inputs; vector table, directed corner sequences and random traffic vs a model.
module tb_hazard_sched_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, idex_memread, ifid_uses_rs2, branch_taken;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;

  logic        pw0, iw0, iff0, idf0, b0;
  logic [31:0] sc0, fc0;
  logic        pw1, iw1, iff1, idf1, b1;
  logic [3:0]  sc1, fc1;

  hazard_sched_ctrl dut0 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .pc_write(pw0), .ifid_write(iw0),
    .ifid_flush(iff0), .idex_flush(idf0), .stall_cnt(sc0), .flush_cnt(fc0), .busy(b0)
  );

  hazard_sched_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .pc_write(pw1), .ifid_write(iw1),
    .ifid_flush(iff1), .idex_flush(idf1), .stall_cnt(sc1), .flush_cnt(fc1), .busy(b1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: remaining bubble / flush cycles as plain integers per instance.
  int     m_sc[2]   = '{1, 3};
  int     m_fc[2]   = '{1, 2};
  longint m_max[2]  = '{64'hFFFF_FFFF, 64'd15};
  int     m_sleft[2];
  int     m_fleft[2];
  longint m_scnt[2];
  longint m_fcnt[2];

  logic [4:0] cap0, cap1;
  longint     cap_sc0, cap_fc0, cap_sc1, cap_fc1;

  typedef struct {
    bit         r, mr;
    logic [4:0] rd, rs1, rs2;
    bit         u, br;
    logic [4:0] exp;  // {pc_write, ifid_write, ifid_flush, idex_flush, busy}
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ref_hazard();
    return idex_memread && idex_rd != 0 &&
           (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
  endfunction

  task automatic model_check();
    logic [4:0] e, a;
    bit         bz;
    for (int m = 0; m < 2; m++) begin
      a = (m == 0) ? cap0 : cap1;
      chk($sformatf("m%0d_stall_cnt", m), (m == 0) ? cap_sc0 : cap_sc1, m_scnt[m]);
      chk($sformatf("m%0d_flush_cnt", m), (m == 0) ? cap_fc0 : cap_fc1, m_fcnt[m]);
      bz = (m_sleft[m] > 0) || (m_fleft[m] > 0);
      if (reset) begin
        e = 5'b00110;
        m_sleft[m] = 0; m_fleft[m] = 0; m_scnt[m] = 0; m_fcnt[m] = 0;
      end else if (branch_taken) begin
        e = {4'b1111, bz};
        if (m_fcnt[m] < m_max[m]) m_fcnt[m]++;
        m_fleft[m] = m_fc[m] - 1;
        m_sleft[m] = 0;
      end else if (m_fleft[m] > 0) begin
        e = {4'b1111, bz};
        m_fleft[m]--;
      end else if (m_sleft[m] > 0) begin
        e = {4'b0001, bz};
        m_sleft[m]--;
      end else if (ref_hazard()) begin
        e = 5'b00010;
        if (m_scnt[m] < m_max[m]) m_scnt[m]++;
        m_sleft[m] = m_sc[m] - 1;
      end else begin
        e = 5'b11000;
      end
      chk($sformatf("m%0d_outs", m), longint'(a), longint'(e));
    end
  endtask

  task automatic drive(input bit r, input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u, input bit br);
    reset = r; idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    ifid_uses_rs2 = u; branch_taken = br;
    @(negedge clk);
    cap0 = {pw0, iw0, iff0, idf0, b0};
    cap1 = {pw1, iw1, iff1, idf1, b1};
    cap_sc0 = longint'(sc0); cap_fc0 = longint'(fc0);
    cap_sc1 = longint'(sc1); cap_fc1 = longint'(fc1);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic rst();
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; idex_memread = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    ifid_uses_rs2 = 1'b0; branch_taken = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_sleft[m] = 0; m_fleft[m] = 0; m_scnt[m] = 0; m_fcnt[m] = 0;
    end
    @(posedge clk);
    #1;

    vecs[0]  = '{1, 0, 5'd0,  5'd0, 5'd0,  0, 0, 5'b00110};
    vecs[1]  = '{0, 0, 5'd0,  5'd0, 5'd0,  0, 0, 5'b11000};
    vecs[2]  = '{0, 1, 5'd5,  5'd5, 5'd0,  0, 0, 5'b00010};
    vecs[3]  = '{0, 1, 5'd7,  5'd1, 5'd7,  0, 0, 5'b11000};
    vecs[4]  = '{0, 1, 5'd7,  5'd1, 5'd7,  1, 0, 5'b00010};
    vecs[5]  = '{0, 1, 5'd0,  5'd0, 5'd0,  1, 0, 5'b11000};
    vecs[6]  = '{0, 0, 5'd5,  5'd5, 5'd5,  1, 0, 5'b11000};
    vecs[7]  = '{0, 1, 5'd5,  5'd5, 5'd0,  0, 1, 5'b11110};
    vecs[8]  = '{0, 0, 5'd0,  5'd0, 5'd0,  0, 1, 5'b11110};
    vecs[9]  = '{1, 1, 5'd5,  5'd5, 5'd0,  0, 1, 5'b00110};
    vecs[10] = '{0, 1, 5'd31, 5'd3, 5'd31, 1, 0, 5'b00010};
    vecs[11] = '{0, 1, 5'd12, 5'd4, 5'd9,  1, 0, 5'b11000};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].r, vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].u, vecs[i].br);
      chk($sformatf("vec%0d_outs", i), longint'(cap0), longint'(vecs[i].exp));
    end

    // Load-use with default and 3-cycle stall instances.
    rst();
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    chk("lu_pw0_c1", cap0[4], 0); chk("lu_pw1_c1", cap1[4], 0); chk("lu_busy1_c1", cap1[0], 0);
    idle();
    chk("lu_pw0_c2", cap0[4], 1); chk("lu_sc0", cap_sc0, 1);
    chk("lu_pw1_c2", cap1[4], 0); chk("lu_busy1_c2", cap1[0], 1);
    idle();
    chk("lu_pw1_c3", cap1[4], 0); chk("lu_busy1_c3", cap1[0], 1);
    idle();
    chk("lu_pw1_c4", cap1[4], 1); chk("lu_busy1_c4", cap1[0], 0); chk("lu_sc1", cap_sc1, 1);

    // Branch with simultaneous hazard: branch wins, no stall counted.
    rst();
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 1);
    chk("bp_outs0", longint'(cap0), longint'(5'b11110));
    idle();
    chk("bp_sc0", cap_sc0, 0); chk("bp_fc0", cap_fc0, 1);

    // Branch aborting a stall (STALL=3, FLUSH=2).
    rst();
    drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    chk("ab_c2", longint'(cap1), longint'(5'b11111));
    idle();
    chk("ab_c3", longint'(cap1), longint'(5'b11111));
    idle();
    chk("ab_c4", longint'(cap1), longint'(5'b11000));
    chk("ab_sc1", cap_sc1, 1); chk("ab_fc1", cap_fc1, 1);

    // Reset in the middle of FLUSH.
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    rst();
    chk("rf_rst", longint'(cap1), longint'(5'b00110));
    idle();
    chk("rf_after", longint'(cap1), longint'(5'b11000));
    chk("rf_sc1", cap_sc1, 0); chk("rf_fc1", cap_fc1, 0);

    // Saturation: hazard held for 20 stall windows of 3 cycles each.
    for (int i = 0; i < 60; i++) drive(0, 1, 5'd3, 5'd3, 5'd0, 0, 0);
    idle();
    chk("sat_sc1", cap_sc1, 15); chk("sat_sc0", cap_sc0, 60);

    // Random traffic: small register space to make hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0), $urandom_range(1) == 1,
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
            $urandom_range(1) == 1, ($urandom_range(7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
